bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the single-bit sequence-detector FSM. Accepts WIDTH-bit words over a valid/ready handshake and drives one bit per clock onto the FSM's serial input `a`. A one-entry holding register allows back-to-back words with no idle cycle between them, so the downstream FSM sees a continuous bit stream.

## Interface
- `WIDTH`, 8: bits per word; legal values are 2 and above.
- `MSB_FIRST`, 1: 1 = shift out bit WIDTH-1 first; 0 = bit 0 first.
- `IDLE_LEVEL`, 0: value driven on `a` when no bit is valid.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `din`  in  WIDTH: word to serialize.
- `din_valid`  in  1: `din` is valid this cycle.
- `din_ready`  out  1: block can accept a word this cycle.
- `a`  out  1: serial bit to the FSM; equals `IDLE_LEVEL` when `a_valid` = 0.
- `a_valid`  out  1: `a` carries a data bit this cycle.
- `last`  out  1: high during the cycle that presents a word's final bit.
- `busy`  out  1: high when the shifter is active or the holding register is full.

## Operation
- **Handshake:** a word transfers on a rising edge where `din_valid` = 1 and `din_ready` = 1. `din_ready` = !hold_full, and it is forced to 0 while `rst` = 1.
- **States:**
  - IDLE: `a_valid` = 0.
  - SHIFT: `a_valid` = 1. `bit_cnt` counts 0 to WIDTH-1.
- **Load source.** At any edge where the shifter is free (state IDLE, or SHIFT with `bit_cnt` = WIDTH-1), the shift register loads from:
  - first priority, the holding register, if it is full;
  - otherwise, `din`, if a handshake occurs.
  - On a load: `bit_cnt` <= 0 and the state goes to SHIFT.
  - With no source: the state goes to IDLE.
- **Holding register:** captures a handshaken word that the shifter does not take at that edge. It clears when its word is moved into the shifter.
- **Simultaneous events:** if the shifter frees up, the holding register is full, and a handshake occurs at the same edge, this cannot happen, because `din_ready` = 0 whenever the holding register is full. Result: at most one word is in flight plus one held.
- **Shift:** each SHIFT cycle presents the current bit on `a`, then advances `bit_cnt` by 1 and shifts the register by one position in the `MSB_FIRST` direction.
- **`last`** = (state == SHIFT) && (`bit_cnt` == WIDTH-1).
- **Width rules:** `bit_cnt` is $clog2(WIDTH) bits wide and never wraps past WIDTH-1; it is reloaded to 0 on every load.
- **Reset mid-word:** `rst` discards the partial word and the held word. There is no partial output after reset.

## Timing
- **Reset values (the cycle after `rst` is sampled high):**
  - state = IDLE, `bit_cnt` = 0, hold_full = 0
  - `a` = `IDLE_LEVEL`, `a_valid` = 0, `last` = 0, `busy` = 0
  - `din_ready` = 0 during reset, 1 in the first cycle after reset is released.
- **Latency:** a word accepted at edge N from IDLE presents its first bit in cycle N+1 and its last bit in cycle N+WIDTH.
- **Throughput:** with continuous `din_valid`, `a_valid` stays 1 indefinitely; one word every WIDTH cycles, with zero gap cycles.
- **Ready behaviour:** `din_ready` drops the cycle after the holding register fills, and returns the cycle after its word moves into the shifter.
- **Output type:** all outputs are registered, or decoded from registered state only. There is no combinational path from `din_valid` to `a` or `a_valid`.

## Structure
- **Shared package `fsm_pkg`:** state encoding constants (ST_IDLE = 1'b0, ST_SHIFT = 1'b1), shared with the downstream FSM's testbench for state printing.
- **One sub-module, `bit_hold_reg`:** the one-entry holding register with its full flag, load input and clear input. The FSM, counter and shifter stay in the top module.

## Test plan
- **Single word:** WIDTH=8, MSB_FIRST=1, `din` = 8'hD6 accepted at edge 0.
  - `a` = 1,1,0,1,0,1,1,0 in cycles 1–8.
  - `last` = 1 only in cycle 8.
  - `a_valid` = 0 and `a` = `IDLE_LEVEL` from cycle 9.
- **LSB-first:** MSB_FIRST=0, `din` = 8'hD6 → `a` = 0,1,1,0,1,0,1,1.
- **Back-to-back:** `din_valid` held at 1 with words 8'hD6, 8'h5A, 8'hFF.
  - 24 consecutive cycles with `a_valid` = 1 and no gap.
  - `din_ready` = 0 while the holding register is full.
  - The bit sequence matches the concatenation of the three words.
- **Backpressure:** hold `din_valid` = 1 with `din` changing every cycle.
  - Only values present at edges where `din_ready` = 1 appear on `a`.
  - No word is duplicated or dropped.
- **Reset mid-word:** assert `rst` for 1 cycle during bit 3 of 8'hD6, with 8'h5A held.
  - The next cycle shows `a_valid` = 0, `busy` = 0, `din_ready` = 0.
  - A fresh word then serializes from bit 0, and 8'h5A never appears.
- **Downstream integration:** drive the FSM's `a` and `clk` from this block with stimulus bits 0,1,1,0,1,0,1,1,0,1,1.
  - FSM `out1`/`out2` match the directed stimulus run from the existing FSM bench, shifted by the 1-cycle serializer latency.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared state encoding for the serializer front end and the downstream
// sequence-detector bench, which uses it when printing states.
package fsm_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_hold_reg.sv
// One-entry holding register for bit_serializer.
// Captures a word that was handshaken while the shifter was still busy.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   i_load    : capture i_din and set full
//   i_clear   : word has moved into the shifter; drop full
//   i_din     : word to capture
//   o_dout    : held word
//   o_full    : register holds a valid word
module bit_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full
);

  logic [WIDTH-1:0] r_data;
  logic             r_full;

  // load only happens while empty and clear only while full,
  // so the two never meet in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_din;
      r_full <= 1'b1;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_dout = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the sequence-detector FSM.
// Takes WIDTH-bit words on a valid/ready handshake and drives one bit per
// clock on `a`. A one-entry holding register lets consecutive words run
// with no idle cycle between them.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   din        : word to serialize
//   din_valid  : din valid this cycle
//   din_ready  : block can accept a word (0 while rst or holding reg full)
//   a          : serial bit, IDLE_LEVEL when a_valid = 0
//   a_valid    : a carries a data bit
//   last       : a carries the final bit of a word
//   busy       : shifter active or holding register full
module bit_serializer
  import fsm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             a,
  output logic             a_valid,
  output logic             last,
  output logic             busy
);

  localparam int              CNT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [WIDTH-1:0] r_shift;

  logic [WIDTH-1:0] w_hold_data;
  logic [WIDTH-1:0] w_load_data;
  logic             w_hold_full;
  logic             w_hs;
  logic             w_free;
  logic             w_load;
  logic             w_hold_cap;
  logic             w_hold_clr;
  logic             w_bit;
  logic             w_at_max;

  assign din_ready = !rst && !w_hold_full;
  assign w_hs      = din_valid && din_ready;
  assign w_at_max  = (r_bit_cnt == CNT_MAX);

  // Load-source selection: the held word always goes first so order is kept.
  // A handshake can only reach the shifter directly when the holding
  // register is empty (din_ready guarantees it is never full at a handshake).
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_data = din;
    w_hold_clr  = 1'b0;
    w_free      = (r_state == ST_IDLE) || ((r_state == ST_SHIFT) && w_at_max);
    if (w_free) begin
      if (w_hold_full) begin
        w_load      = 1'b1;
        w_load_data = w_hold_data;
        w_hold_clr  = 1'b1;
      end else if (w_hs) begin
        w_load = 1'b1;
      end
      w_state_nxt = w_load ? ST_SHIFT : ST_IDLE;
    end
    // Any handshake the shifter did not take goes into the holding register.
    w_hold_cap = w_hs && !(w_load && !w_hold_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_load) begin
      r_bit_cnt <= '0;
      r_shift   <= w_load_data;
    end else if (r_state == ST_SHIFT) begin
      // Finishing a word with nothing to load: park the counter at 0
      // instead of letting it run past WIDTH-1.
      r_bit_cnt <= w_at_max ? '0 : r_bit_cnt + CNT_W'(1);
      if (MSB_FIRST) r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      else           r_shift <= {1'b0, r_shift[WIDTH-1:1]};
    end
  end

  bit_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_hold_cap),
    .i_clear (w_hold_clr),
    .i_din   (din),
    .o_dout  (w_hold_data),
    .o_full  (w_hold_full)
  );

  // Outputs decode registered state only; din_valid never reaches a/a_valid.
  assign w_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign a_valid = (r_state == ST_SHIFT);
  assign a       = a_valid ? w_bit : IDLE_LEVEL;
  assign last    = a_valid && w_at_max;
  assign busy    = a_valid || w_hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first/idle-0 instance and an
// LSB-first/idle-1 instance share the same stimulus.
module tb_bit_serializer;

  typedef logic [7:0] wq_t[$];

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic       a;
    logic       av;
    logic       lst;
    logic       rdy;
    logic       bsy;
    logic       a1;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid;
  logic [7:0] din;
  logic       rdy0, a0, av0, l0, b0;
  logic       rdy1, a1, av1, l1, b1;

  int total = 0;
  int bad   = 0;

  bit q0[$];
  bit q1[$];
  int cyc, first_v, last_v, nv;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy0),
    .a(a0), .a_valid(av0), .last(l0), .busy(b0)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy1),
    .a(a1), .a_valid(av1), .last(l1), .busy(b1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later and record any valid bits.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (av0 === 1'b1) begin
      q0.push_back(a0);
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
      nv++;
    end
    if (av1 === 1'b1) q1.push_back(a1);
  endtask

  task automatic clr();
    q0.delete();
    q1.delete();
    cyc = 0; first_v = -1; last_v = -1; nv = 0;
  endtask

  // Reassemble the recorded bits into words (MSB-first for dut0,
  // LSB-first for dut1) and check gap-free delivery.
  task automatic check_stream(input string nm, input wq_t exp);
    logic [7:0] w0, w1;
    chk({nm, "_len0"}, q0.size(), exp.size() * 8);
    chk({nm, "_len1"}, q1.size(), exp.size() * 8);
    chk({nm, "_nv"}, nv, exp.size() * 8);
    chk({nm, "_span"}, last_v - first_v + 1, exp.size() * 8);
    for (int k = 0; k < exp.size(); k++) begin
      if (q0.size() >= 8 * (k + 1) && q1.size() >= 8 * (k + 1)) begin
        for (int i = 0; i < 8; i++) begin
          w0[7 - i] = q0[8 * k + i];
          w1[i]     = q1[8 * k + i];
        end
        chk($sformatf("%s_msb_w%0d", nm, k), w0, exp[k]);
        chk($sformatf("%s_lsb_w%0d", nm, k), w1, exp[k]);
      end
    end
  endtask

  vec_t tbl[10];
  wq_t  e;
  logic [7:0] words[3];
  int   idx, low;
  logic hs;

  initial begin
    // single word 8'hD6 accepted at row 0: MSB 1,1,0,1,0,1,1,0 / LSB 0,1,1,0,1,0,1,1
    tbl[0] = '{1'b1, 8'hD6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    clr();
    rst = 1'b1; din_valid = 1'b0; din = 8'h00;
    tick(); tick();
    chk("rst_av0",  av0,  1'b0);
    chk("rst_a0",   a0,   1'b0);
    chk("rst_a1",   a1,   1'b1);
    chk("rst_last", l0,   1'b0);
    chk("rst_busy", b0,   1'b0);
    chk("rst_rdy",  rdy0, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_rel_rdy", rdy0, 1'b1);

    // table-driven single word
    for (int i = 0; i < 10; i++) begin
      din_valid = tbl[i].vld;
      din       = tbl[i].din;
      tick();
      chk($sformatf("row%0d_a", i),    a0,   tbl[i].a);
      chk($sformatf("row%0d_av", i),   av0,  tbl[i].av);
      chk($sformatf("row%0d_last", i), l0,   tbl[i].lst);
      chk($sformatf("row%0d_rdy", i),  rdy0, tbl[i].rdy);
      chk($sformatf("row%0d_busy", i), b0,   tbl[i].bsy);
      chk($sformatf("row%0d_a1", i),   a1,   tbl[i].a1);
      chk($sformatf("row%0d_av1", i),  av1,  tbl[i].av);
    end

    // back-to-back: source presents the next word once the previous one
    // handshakes; holding register is full for 7 cycles per overlap
    clr();
    words[0] = 8'hD6; words[1] = 8'h5A; words[2] = 8'hFF;
    idx = 0; low = 0;
    for (int c = 0; c < 30; c++) begin
      din_valid = (idx < 3);
      din       = (idx < 3) ? words[idx] : 8'h00;
      hs        = din_valid && rdy0;
      tick();
      if (hs) idx++;
      if (!rdy0) low++;
    end
    din_valid = 1'b0;
    chk("b2b_accepted", idx, 3);
    chk("b2b_ready_low", low, 14);
    e.delete(); e.push_back(8'hD6); e.push_back(8'h5A); e.push_back(8'hFF);
    check_stream("b2b", e);

    // backpressure: din changes every cycle, valid always high
    clr();
    for (int c = 0; c < 40; c++) begin
      din_valid = 1'b1;
      din       = 8'h10 + 8'(c);
      tick();
    end
    din_valid = 1'b0;
    din       = 8'h00;
    for (int c = 0; c < 20; c++) tick();
    e.delete();
    e.push_back(8'h10); e.push_back(8'h11); e.push_back(8'h19);
    e.push_back(8'h21); e.push_back(8'h29); e.push_back(8'h31);
    check_stream("bp", e);

    // reset during bit 3 of 8'hD6 while 8'h5A sits in the holding register
    clr();
    din_valid = 1'b1; din = 8'hD6; tick();
    din = 8'h5A; tick();
    din_valid = 1'b0; din = 8'h00;
    tick(); tick();
    chk("mid_bit3", a0, 1'b1);
    chk("mid_busy", b0, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst_av",   av0,  1'b0);
    chk("mid_rst_busy", b0,   1'b0);
    chk("mid_rst_rdy",  rdy0, 1'b0);
    chk("mid_rst_a",    a0,   1'b0);
    rst = 1'b0;
    clr();
    for (int c = 0; c < 10; c++) tick();
    chk("mid_no_stale", q0.size(), 0);
    clr();
    din_valid = 1'b1; din = 8'hA3; tick();
    din_valid = 1'b0; din = 8'h00;
    for (int c = 0; c < 15; c++) tick();
    e.delete(); e.push_back(8'hA3);
    check_stream("mid_fresh", e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
